// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: the start/busy/done handshake plus operands and results.
// The master modport drives the request side; the slave modport is the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;
    logic             o_overflow;

    modport master (
        output i_start, i_a, i_b, i_bin,
        input  o_busy, o_done, o_diff, o_bout, o_overflow
    );

    modport slave (
        input  i_start, i_a, i_b, i_bin,
        output o_busy, o_done, o_diff, o_bout, o_overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, LSB first, one full-adder cell per clock.
// Define SERIAL_SUB_OVERFLOW_EN to register signed overflow; otherwise o_overflow is tied to 0.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_diff_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    // Subtraction as A + ~B + ~Bin: the carry chain starts at ~Bin and the B bit is inverted.
    assign w_sum       = r_a[0] ^ ~r_b[0] ^ r_carry;
    assign w_cout      = (r_a[0] & ~r_b[0]) | (r_a[0] & r_carry) | (~r_b[0] & r_carry);
    assign w_diff_next = {w_sum, r_diff_sh[WIDTH-1:1]};
    assign w_last      = (r_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_diff_sh <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_cnt   <= '0;
            r_carry <= ~bus.i_bin;
        end else if (r_state == S_RUN) begin
            r_a       <= r_a >> 1;
            r_b       <= r_b >> 1;
            r_diff_sh <= w_diff_next;
            r_carry   <= w_cout;
            r_cnt     <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff <= w_diff_next;
                r_bout <= ~w_cout;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_overflow;

    // On the last RUN step r_carry is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (!w_load && r_state == S_RUN && w_last) begin
            r_overflow <= r_carry ^ w_cout;
        end
    end

    assign bus.o_overflow = r_overflow;
`else
    assign bus.o_overflow = 1'b0;
`endif

    assign bus.o_busy = (r_state == S_RUN);
    assign bus.o_done = (r_state == S_DONE);
    assign bus.o_diff = r_diff;
    assign bus.o_bout = r_bout;
endmodule
